byte_pass_sequencer: RTL

Upstream sequencer for the 16-bit calculator's 8-bit datapath. It captures two 16-bit operands and an operator code, then runs two 8-bit ALU passes: low byte first, then high byte. The low-pass carry or borrow is chained into the high pass. It drives `islow`, `sign_q` and `carry_lo` directly into the carry/borrow flag stage, and returns the assembled 16-bit result with final flags.

---
 rtl/calc_pkg.sv | 23 ++
 rtl/alu8.sv | 44 ++++
 rtl/byte_pass_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: operator codes, sequencer state encoding and
// a legality helper. The flag stage and the keypad/display logic import this too.
package calc_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOW  = 2'b01,
    ST_HIGH = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // Codes above OP_SUB have no defined operation.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_SUB);
  endfunction

endpackage

// File: rtl/alu8.sv
// Single-pass byte ALU shared by the low and high passes of the sequencer.
// SUB is formed as x + ~y + cin, so cout = 1 means "no borrow".
module alu8
  import calc_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [2:0]   op,
  input  logic         cin,
  output logic [W-1:0] r,
  output logic         cout
);

  logic [W-1:0] y_eff;
  logic [W:0]   sum;

  // Explicit W+1-bit sum; the top bit is the carry out of the pass.
  always_comb begin
    y_eff = (op == OP_SUB) ? ~y : y;
    sum   = {1'b0, x} + {1'b0, y_eff} + {{W{1'b0}}, cin};
  end

  // Operator select; logic ops never produce a carry, illegal codes give zero.
  always_comb begin
    r    = '0;
    cout = 1'b0;
    case (op)
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_XOR: r = x ^ y;
      OP_ADD, OP_SUB: begin
        r    = sum[W-1:0];
        cout = sum[W];
      end
      default: begin
        r    = '0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/byte_pass_sequencer.sv
// Two-pass sequencer: runs a WIDTH-bit operation through one shared
// (WIDTH/2)-bit ALU, low half first, chaining the low-pass carry into the
// high pass. islow, sign_q and carry_lo feed the downstream flag stage.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; operands captured on the accepting edge
//   LOW     | low half on the ALU; result low half and carry_lo at exit
//   HIGH    | high half with carry_lo chained; result high, carry, ovf
//   DONE    | done pulse; result and flags valid
module byte_pass_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sign,
  output logic             busy,
  output logic             islow,
  output logic [2:0]       sign_q,
  output logic             carry_lo,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             err,
  output logic             done
);

  localparam int unsigned H = WIDTH / 2;

  state_t         state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [H-1:0] alu_x;
  logic [H-1:0] alu_y;
  logic         alu_cin;
  logic [H-1:0] alu_r;
  logic         alu_cout;
  logic         ovf_next;

  // Operand half select: the high half only in HIGH, the low half otherwise.
  // SUB's low pass needs cin=1 so that x + ~y + 1 is a true subtract.
  always_comb begin
    alu_x   = a_q[H-1:0];
    alu_y   = b_q[H-1:0];
    alu_cin = (sign_q == OP_SUB);
    if (state == ST_HIGH) begin
      alu_x   = a_q[WIDTH-1:H];
      alu_y   = b_q[WIDTH-1:H];
      alu_cin = carry_lo;
    end
  end

  alu8 #(.W(H)) u_alu (
    .x    (alu_x),
    .y    (alu_y),
    .op   (sign_q),
    .cin  (alu_cin),
    .r    (alu_r),
    .cout (alu_cout)
  );

  // Signed overflow from operand sign bits and the high-pass result sign.
  always_comb begin
    ovf_next = 1'b0;
    case (sign_q)
      OP_ADD: ovf_next = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_r[H-1] != a_q[WIDTH-1]);
      OP_SUB: ovf_next = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_r[H-1] != a_q[WIDTH-1]);
      default: ovf_next = 1'b0;
    endcase
  end

  // Sequencer FSM with registered status outputs and result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 3'b000;
      busy     <= 1'b0;
      islow    <= 1'b0;
      carry_lo <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      ovf      <= 1'b0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            sign_q <= sign;
            err    <= ~op_is_legal(sign);
            carry  <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b1;
            islow  <= 1'b1;
            state  <= ST_LOW;
          end
        end
        ST_LOW: begin
          // The ALU already returns zero for illegal codes; err forces it anyway
          // so the flag stage never sees a stray carry on an illegal operation.
          result[H-1:0] <= err ? '0 : alu_r;
          carry_lo      <= err ? 1'b0 : alu_cout;
          islow         <= 1'b0;
          state         <= ST_HIGH;
        end
        ST_HIGH: begin
          result[WIDTH-1:H] <= err ? '0 : alu_r;
          carry             <= err ? 1'b0 : alu_cout;
          ovf               <= err ? 1'b0 : ovf_next;
          done              <= 1'b1;
          state             <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          islow <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
